// File: rtl/sys_array_result_deskew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sys_array_pkg                                                    |
// | Shared psum widths and row-packing helpers for the systolic array blocks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sys_array_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int ACC_WIDTH      = 2 * DEF_DATA_WIDTH;

    typedef logic signed [ACC_WIDTH-1:0] psum_t;

    function automatic int acc_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int row_width(input int array_w, input int data_width);
        return array_w * acc_width(data_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_array_result_deskew_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : sys_array_result_deskew_if                                     |
// | Bottom-row psum input and aligned-row FIFO output of the deskew block.     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface sys_array_result_deskew_if
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_W    = 4,
    parameter int FIFO_DEPTH = 8
);
    localparam int ROW_W = row_width(ARRAY_W, DATA_WIDTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic [ROW_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic [CNT_W-1:0] fifo_count;
    logic             almost_full;
    logic             overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, fifo_count, almost_full, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, fifo_count, almost_full, overflow
    );

endinterface
`default_nettype wire

// File: rtl/sys_array_skew_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sys_array_skew_delay                                             |
// | DEPTH-stage shift register with synchronous reset; DEPTH=0 is a wire.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sys_array_skew_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ reset;
        assign q_o      = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/sys_array_result_deskew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sys_array_result_deskew                                          |
// | Re-aligns skewed bottom-row psums into rows and buffers them in a FIFO.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sys_array_result_deskew
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_W    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input wire logic               clk,
    input wire logic               reset,
    sys_array_result_deskew_if.slave io
);

    localparam int ACC_W = acc_width(DATA_WIDTH);
    localparam int ROW_W = row_width(ARRAY_W, DATA_WIDTH);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(FIFO_DEPTH - ARRAY_W);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [ROW_W-1:0] w_row_data;
    logic             w_row_valid;

    // Column j arrives j cycles late, so it gets ARRAY_W-1-j stages to line up.
    for (genvar j = 0; j < ARRAY_W; j++) begin : g_col
        sys_array_skew_delay #(
            .WIDTH (ACC_W),
            .DEPTH (ARRAY_W - 1 - j)
        ) u_col_dly (
            .clk   (clk),
            .reset (reset),
            .d_i   (io.in_data[j*ACC_W +: ACC_W]),
            .q_o   (w_row_data[j*ACC_W +: ACC_W])
        );
    end

    sys_array_skew_delay #(
        .WIDTH (1),
        .DEPTH (ARRAY_W - 1)
    ) u_vld_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (io.in_valid),
        .q_o   (w_row_valid)
    );

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             w_empty, w_pop, w_push;

    assign w_empty = (count_q == '0);
    assign w_pop   = !w_empty && io.out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_push  = w_row_valid && ((count_q != DEPTH_C) || w_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (w_row_valid & ~w_push);
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_row_data;
        end
    end

    assign io.out_valid   = !w_empty;
    assign io.out_data    = w_empty ? '0 : mem_q[rd_ptr_q];
    assign io.fifo_count  = count_q;
    assign io.almost_full = (count_q >= AF_C);
    assign io.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_result_deskew.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sys_array_result_deskew                                       |
// | Directed self-checking bench for the result deskew FIFO (4 cols, depth 8). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sys_array_result_deskew;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] fut [4];
    logic [63:0] q [$];

    always #5 clk = ~clk;

    sys_array_result_deskew_if #(.DATA_WIDTH(8), .ARRAY_W(4), .FIFO_DEPTH(8)) bus ();

    sys_array_result_deskew #(.DATA_WIDTH(8), .ARRAY_W(4), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    function automatic logic [63:0] srow(input logic [15:0] base, input int r);
        logic [15:0] b;
        b = base + 16'(r * 16);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each column of a row is placed j cycles in the future; unused slots carry junk.
    task automatic step(input bit v, input logic [63:0] row, input bit rdy);
        if (v) begin
            for (int j = 0; j < 4; j++) fut[j][j*16 +: 16] = row[j*16 +: 16];
        end
        bus.in_valid  = v;
        bus.in_data   = fut[0];
        bus.out_ready = rdy;
        fut[0] = fut[1];
        fut[1] = fut[2];
        fut[2] = fut[3];
        fut[3] = {4{16'hBAD0}};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_data"},  bus.out_data, 64'd0);
        chk({tag, "_count"}, 64'(bus.fifo_count), 64'd0);
        chk({tag, "_af"},    64'(bus.almost_full), 64'd0);
        chk({tag, "_ovf"},   64'(bus.overflow), 64'd0);
    endtask

    initial begin
        int sent;
        int got;
        int exp_cnt;
        logic [63:0] exp_row;
        for (int d = 0; d < 4; d++) fut[d] = {4{16'hBAD0}};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step(0, '0, 0);
        step(0, '0, 0);
        chk_cleared("rst");
        reset = 1'b0;

        // 1: single row, latency 4, then popped
        step(1, {16'd13, 16'd12, 16'd11, 16'd10}, 1);
        chk("t1_lat1", 64'(bus.out_valid), 64'd0);
        step(0, '0, 1);
        chk("t1_lat2", 64'(bus.out_valid), 64'd0);
        step(0, '0, 1);
        chk("t1_lat3", 64'(bus.out_valid), 64'd0);
        step(0, '0, 1);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data", bus.out_data, 64'h000D_000C_000B_000A);
        chk("t1_count", 64'(bus.fifo_count), 64'd1);
        step(0, '0, 1);
        chk("t1_popped", 64'(bus.out_valid), 64'd0);
        chk("t1_count0", 64'(bus.fifo_count), 64'd0);

        // 2: signed extremes carried bit-exact
        step(1, {16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF}, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("t2_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_data", bus.out_data, 64'h0000_7FFF_8000_FFFF);
        step(0, '0, 1);
        chk("t2_popped", 64'(bus.fifo_count), 64'd0);

        // 3: six back-to-back rows streamed out one per cycle
        for (int k = 1; k <= 12; k++) begin
            step(k <= 6, srow(16'h3000, k - 1), 1);
            chk("t3_valid", 64'(bus.out_valid), 64'(k >= 4 && k <= 9));
            if (k >= 4 && k <= 9) chk("t3_data", bus.out_data, srow(16'h3000, k - 4));
            chk("t3_cnt_le1", 64'(bus.fifo_count <= 1), 64'd1);
        end

        // 4a: fill with out_ready low
        for (int k = 1; k <= 11; k++) begin
            step(k <= 8, srow(16'h4000, k - 1), 0);
            exp_cnt = (k >= 4) ? k - 3 : 0;
            chk("t4_count", 64'(bus.fifo_count), 64'(exp_cnt));
            chk("t4_af", 64'(bus.almost_full), 64'(exp_cnt >= 4));
            chk("t4_ovf", 64'(bus.overflow), 64'd0);
        end
        chk("t4_head", bus.out_data, srow(16'h4000, 0));

        // 4b: full FIFO, pop and push in the same cycle
        step(1, srow(16'h4000, 8), 0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("t4b_head0", bus.out_data, srow(16'h4000, 0));
        step(0, '0, 1);
        chk("t4b_count", 64'(bus.fifo_count), 64'd8);
        chk("t4b_ovf", 64'(bus.overflow), 64'd0);
        chk("t4b_head1", bus.out_data, srow(16'h4000, 1));

        // 4c: row arriving at a full FIFO is dropped
        step(1, srow(16'h4000, 15), 0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("t4c_ovf_early", 64'(bus.overflow), 64'd0);
        step(0, '0, 0);
        chk("t4c_ovf", 64'(bus.overflow), 64'd1);
        chk("t4c_count", 64'(bus.fifo_count), 64'd8);

        // 4d: drain; dropped row must not appear
        for (int i = 0; i < 8; i++) begin
            chk("t4d_valid", 64'(bus.out_valid), 64'd1);
            chk("t4d_data", bus.out_data, srow(16'h4000, i + 1));
            step(0, '0, 1);
        end
        chk("t4d_empty", 64'(bus.out_valid), 64'd0);
        chk("t4d_data0", bus.out_data, 64'd0);
        chk("t4d_ovf_sticky", 64'(bus.overflow), 64'd1);
        reset = 1'b1;
        step(0, '0, 0);
        reset = 1'b0;
        chk("t4d_ovf_clr", 64'(bus.overflow), 64'd0);

        // 5: 20 rows, out_ready toggling, pointers wrap
        sent = 0;
        got  = 0;
        for (int c = 0; c < 120 && got < 20; c++) begin
            if (bus.out_valid && (c % 2 == 1)) begin
                if (q.size() == 0) begin
                    chk("t5_spurious", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_row = q.pop_front();
                    chk("t5_order", bus.out_data, exp_row);
                    got++;
                end
            end
            if ((c % 4 < 2) && sent < 20) begin
                q.push_back(srow(16'h5000, sent));
                step(1, srow(16'h5000, sent), c % 2 == 1);
                sent++;
            end else begin
                step(0, '0, c % 2 == 1);
            end
        end
        chk("t5_got", 64'(got), 64'd20);
        chk("t5_count", 64'(bus.fifo_count), 64'd0);
        chk("t5_ovf", 64'(bus.overflow), 64'd0);

        // 6: reset mid-row with rows stored
        for (int r = 0; r < 3; r++) step(1, srow(16'h6000, r), 0);
        for (int r = 0; r < 3; r++) step(0, '0, 0);
        chk("t6_stored", 64'(bus.fifo_count), 64'd3);
        step(1, srow(16'h6000, 3), 0);
        step(0, '0, 0);
        reset = 1'b1;
        step(0, '0, 0);
        chk_cleared("t6_rst");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(0, '0, 0);
            chk("t6_no_ghost", 64'(bus.out_valid), 64'd0);
        end
        step(1, srow(16'h6000, 4), 0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("t6_lat3", 64'(bus.out_valid), 64'd0);
        step(0, '0, 0);
        chk("t6_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_data", bus.out_data, srow(16'h6000, 4));
        chk("t6_count", 64'(bus.fifo_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
